// File: rtl/muldiv_unit.sv
// Multi-cycle multiply / divide / multiply-accumulate unit for the EX stage.
// Produces a {HI,LO} pair with a one-cycle write pulse and stalls the pipe while busy.
module muldiv_unit #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] opdata1_i,
    input  logic [WIDTH-1:0] opdata2_i,
    input  logic             annul_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] mem_hi_i,
    input  logic [WIDTH-1:0] mem_lo_i,
    input  logic             mem_whilo_i,
    input  logic [WIDTH-1:0] wb_hi_i,
    input  logic [WIDTH-1:0] wb_lo_i,
    input  logic             wb_whilo_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             whilo_o,
    output logic             stallreq_o,
    output logic             div_by_zero_o,
    output logic             busy_o
);

    localparam int unsigned DW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   opa_q;
    logic [WIDTH-1:0]   opb_q;
    logic [DW-1:0]      hilo_q;
    logic [WIDTH-1:0]   dvd_q;   // dividend magnitude, shifted left as quotient bits enter
    logic [WIDTH-1:0]   dvs_q;
    logic [WIDTH-1:0]   rem_q;
    logic               q_neg_q;
    logic               r_neg_q;
    logic               done_q;
    logic               dbz_q;

    logic [WIDTH-1:0]   fwd_hi;
    logic [WIDTH-1:0]   fwd_lo;
    logic               is_mul_op;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [DW-1:0]      ext_a;
    logic [DW-1:0]      ext_b;
    logic [DW-1:0]      product;
    logic [DW-1:0]      mul_res;
    logic [WIDTH:0]     partial;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   rem_nx;
    logic [WIDTH-1:0]   quo_nx;
    logic [WIDTH-1:0]   quo_fin;
    logic [WIDTH-1:0]   rem_fin;

    // HI/LO forwarding: MEM beats WB beats architectural registers
    always_comb begin
        fwd_hi = hi_i;
        fwd_lo = lo_i;
        if (mem_whilo_i) begin
            fwd_hi = mem_hi_i;
            fwd_lo = mem_lo_i;
        end else if (wb_whilo_i) begin
            fwd_hi = wb_hi_i;
            fwd_lo = wb_lo_i;
        end
    end

    // Operand decode and magnitudes for the divider
    always_comb begin
        is_mul_op = op_i[2] | ~op_i[1];
        a_neg     = ~op_i[0] & opdata1_i[WIDTH-1];
        b_neg     = ~op_i[0] & opdata2_i[WIDTH-1];
        a_mag     = a_neg ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
        b_mag     = b_neg ? (~opdata2_i + WIDTH'(1)) : opdata2_i;
    end

    // Full-width product (sign-extended for even op codes) and accumulate
    always_comb begin
        ext_a   = op_q[0] ? {{WIDTH{1'b0}}, opa_q} : {{WIDTH{opa_q[WIDTH-1]}}, opa_q};
        ext_b   = op_q[0] ? {{WIDTH{1'b0}}, opb_q} : {{WIDTH{opb_q[WIDTH-1]}}, opb_q};
        product = ext_a * ext_b;
        mul_res = product;
        if (op_q[2]) begin
            mul_res = op_q[1] ? (hilo_q - product) : (hilo_q + product);
        end
    end

    // One restoring-division step plus final sign fix-up
    always_comb begin
        partial = {rem_q, dvd_q[WIDTH-1]};
        diff    = partial - {1'b0, dvs_q};
        rem_nx  = diff[WIDTH] ? partial[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_nx  = {dvd_q[WIDTH-2:0], ~diff[WIDTH]};
        quo_fin = q_neg_q ? (~quo_nx + WIDTH'(1)) : quo_nx;
        rem_fin = r_neg_q ? (~rem_nx + WIDTH'(1)) : rem_nx;
    end

    // Control FSM with datapath registers and registered result
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            op_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            hilo_q  <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            hi_o    <= '0;
            lo_o    <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            hi_o   <= '0;
            lo_o   <= '0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i && !annul_i) begin
                        op_q   <= op_i;
                        opa_q  <= opdata1_i;
                        opb_q  <= opdata2_i;
                        hilo_q <= {fwd_hi, fwd_lo};
                        if (is_mul_op) begin
                            state <= S_MUL;
                            cnt   <= CNT_W'(MUL_CYCLES - 1);
                        end else if (opdata2_i == '0) begin
                            state  <= S_DONE;
                            hi_o   <= opdata1_i;
                            lo_o   <= '1;
                            done_q <= 1'b1;
                            dbz_q  <= 1'b1;
                        end else begin
                            state   <= S_DIV;
                            cnt     <= CNT_W'(WIDTH - 1);
                            dvd_q   <= a_mag;
                            dvs_q   <= b_mag;
                            rem_q   <= '0;
                            q_neg_q <= a_neg ^ b_neg;
                            r_neg_q <= a_neg;
                        end
                    end
                end
                S_MUL: begin
                    if (annul_i) begin
                        state <= S_IDLE;
                    end else if (cnt == '0) begin
                        state  <= S_DONE;
                        hi_o   <= mul_res[DW-1:WIDTH];
                        lo_o   <= mul_res[WIDTH-1:0];
                        done_q <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_DIV: begin
                    if (annul_i) begin
                        state <= S_IDLE;
                    end else begin
                        rem_q <= rem_nx;
                        dvd_q <= quo_nx;
                        if (cnt == '0) begin
                            state  <= S_DONE;
                            hi_o   <= rem_fin;
                            lo_o   <= quo_fin;
                            done_q <= 1'b1;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Stall request and flush-gated write strobes
    always_comb begin
        stallreq_o = 1'b0;
        case (state)
            S_IDLE:  stallreq_o = start_i & ~annul_i;
            S_MUL:   stallreq_o = ~annul_i;
            S_DIV:   stallreq_o = ~annul_i;
            default: stallreq_o = 1'b0;
        endcase
        whilo_o       = done_q & ~annul_i;
        div_by_zero_o = dbz_q & ~annul_i;
        busy_o        = (state != S_IDLE);
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected {HI,LO} queued at issue, popped on whilo_o.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] opdata1_i, opdata2_i;
    logic        annul_i;
    logic [31:0] hi_i, lo_i, mem_hi_i, mem_lo_i, wb_hi_i, wb_lo_i;
    logic        mem_whilo_i, wb_whilo_i;
    logic [31:0] hi_o, lo_o;
    logic        whilo_o, stallreq_o, div_by_zero_o, busy_o;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t sb[$];
    int   cmp_cnt;
    int   err_cnt;
    int   stall_cnt;
    bit   whilo_seen;

    muldiv_unit #(.WIDTH(32), .MUL_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
        .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .annul_i(annul_i),
        .hi_i(hi_i), .lo_i(lo_i), .mem_hi_i(mem_hi_i), .mem_lo_i(mem_lo_i),
        .mem_whilo_i(mem_whilo_i), .wb_hi_i(wb_hi_i), .wb_lo_i(wb_lo_i),
        .wb_whilo_i(wb_whilo_i), .hi_o(hi_o), .lo_o(lo_o), .whilo_o(whilo_o),
        .stallreq_o(stallreq_o), .div_by_zero_o(div_by_zero_o), .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (stallreq_o === 1'b1) stall_cnt = stall_cnt + 1;
        if (whilo_o === 1'b1) whilo_seen = 1'b1;
    end

    // Present an instruction in IDLE; it is held until its DONE cycle passes
    task automatic drive_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input bit push, input logic [31:0] ehi, input logic [31:0] elo,
                            input logic edbz);
        exp_t e;
        start_i   = 1'b1;
        op_i      = op;
        opdata1_i = a;
        opdata2_i = b;
        if (push) begin
            e.hi = ehi; e.lo = elo; e.dbz = edbz;
            sb.push_back(e);
        end
        @(negedge clk);
        cmp_cnt++;
        if (busy_o !== 1'b0 || whilo_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL idle_before_accept: busy_o=%b whilo_o=%b required 0/0", busy_o, whilo_o);
        end
        @(posedge clk); #1;
    endtask

    // Wait (bounded) for the write pulse, check latency and pop/compare the scoreboard
    task automatic wait_result(input int exp_lat, input string name);
        int   n;
        bit   seen;
        exp_t e;
        n = 0; seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            if (whilo_o === 1'b1) seen = 1'b1;
            else @(posedge clk);
        end
        cmp_cnt++;
        if (!seen || n != exp_lat) begin
            err_cnt++;
            $display("FAIL %s_latency: got %0d (seen=%0b) required %0d", name, n, seen, exp_lat);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (seen) begin
                cmp_cnt++;
                if (hi_o !== e.hi) begin
                    err_cnt++;
                    $display("FAIL %s_hi: got %h required %h", name, hi_o, e.hi);
                end
                cmp_cnt++;
                if (lo_o !== e.lo) begin
                    err_cnt++;
                    $display("FAIL %s_lo: got %h required %h", name, lo_o, e.lo);
                end
                cmp_cnt++;
                if (div_by_zero_o !== e.dbz) begin
                    err_cnt++;
                    $display("FAIL %s_dbz: got %b required %b", name, div_by_zero_o, e.dbz);
                end
            end
        end
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_i = 1'b1;
        op_i = 3'b000;
        opdata1_i = 32'd3;
        opdata2_i = 32'd4;
        repeat (3) @(posedge clk);
        @(negedge clk);
        cmp_cnt++;
        if (hi_o !== 32'h0 || lo_o !== 32'h0) begin
            err_cnt++;
            $display("FAIL reset_hilo: got %h/%h required 0/0", hi_o, lo_o);
        end
        cmp_cnt++;
        if (whilo_o !== 1'b0 || div_by_zero_o !== 1'b0 || busy_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_ctrl: whilo=%b dbz=%b busy=%b required 0/0/0",
                     whilo_o, div_by_zero_o, busy_o);
        end
        @(posedge clk); #1;
        start_i = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mult();
        stall_cnt = 0;
        drive_op(3'b000, 32'hFFFF_FFFD, 32'd5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        wait_result(2, "mult");
        cmp_cnt++;
        if (stall_cnt != 2) begin
            err_cnt++;
            $display("FAIL mult_stall_cycles: got %0d required 2", stall_cnt);
        end
        drive_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        wait_result(2, "multu");
    endtask

    task automatic test_back_to_back();
        drive_op(3'b010, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        wait_result(33, "div_neg7_2");
        drive_op(3'b011, 32'hFFFF_FFFF, 32'h10, 1'b1, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0);
        wait_result(33, "divu");
        drive_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0, 32'h8000_0000, 1'b0);
        wait_result(33, "div_min_m1");
        drive_op(3'b010, 32'd7, 32'hFFFF_FFFE, 1'b1, 32'h1, 32'hFFFF_FFFD, 1'b0);
        wait_result(33, "div_7_m2");
    endtask

    task automatic test_forward();
        hi_i = 32'd7; lo_i = 32'd7;
        wb_whilo_i = 1'b1; wb_hi_i = 32'h1; wb_lo_i = 32'hFFFF_FFFF;
        mem_whilo_i = 1'b1; mem_hi_i = 32'h0; mem_lo_i = 32'hFFFF_FFFE;
        drive_op(3'b100, 32'd2, 32'd3, 1'b1, 32'h1, 32'h4, 1'b0);
        wait_result(2, "madd_mem");
        mem_whilo_i = 1'b0;
        drive_op(3'b100, 32'd2, 32'd3, 1'b1, 32'h2, 32'h5, 1'b0);
        wait_result(2, "madd_wb");
        wb_whilo_i = 1'b0; hi_i = 32'h0; lo_i = 32'd10;
        drive_op(3'b110, 32'd3, 32'd4, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        wait_result(2, "msub_arch");
    endtask

    task automatic test_div_zero();
        drive_op(3'b010, 32'd9, 32'd0, 1'b1, 32'd9, 32'hFFFF_FFFF, 1'b1);
        wait_result(1, "div_zero");
        @(negedge clk);
        cmp_cnt++;
        if (div_by_zero_o !== 1'b0 || whilo_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL div_zero_pulse_width: dbz=%b whilo=%b required 0/0", div_by_zero_o, whilo_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_annul();
        whilo_seen = 1'b0;
        drive_op(3'b010, 32'd100, 32'd3, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (9) begin @(posedge clk); #1; end
        annul_i = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        cmp_cnt++;
        if (stallreq_o !== 1'b0 || whilo_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL annul_same_cycle: stallreq=%b whilo=%b required 0/0", stallreq_o, whilo_o);
        end
        @(posedge clk); #1;
        annul_i = 1'b0;
        @(negedge clk);
        cmp_cnt++;
        if (busy_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL annul_idle: busy=%b required 0", busy_o);
        end
        repeat (40) @(posedge clk);
        #1;
        cmp_cnt++;
        if (whilo_seen !== 1'b0) begin
            err_cnt++;
            $display("FAIL annul_no_write: whilo seen=%b required 0", whilo_seen);
        end
    endtask

    task automatic test_reset_mid();
        whilo_seen = 1'b0;
        drive_op(3'b010, 32'd50, 32'd7, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        start_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        cmp_cnt++;
        if (busy_o !== 1'b0 || hi_o !== 32'h0 || lo_o !== 32'h0 || whilo_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_mid_state: busy=%b hi=%h lo=%h whilo=%b required 0/0/0/0",
                     busy_o, hi_o, lo_o, whilo_o);
        end
        repeat (40) @(posedge clk);
        #1;
        cmp_cnt++;
        if (whilo_seen !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_mid_no_write: whilo seen=%b required 0", whilo_seen);
        end
        hi_i = 32'h0; lo_i = 32'h0; mem_whilo_i = 1'b0; wb_whilo_i = 1'b0;
        drive_op(3'b111, 32'd1, 32'd1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_result(2, "msubu");
    endtask

    initial begin
        cmp_cnt = 0; err_cnt = 0; stall_cnt = 0; whilo_seen = 1'b0;
        rst = 1'b1; start_i = 1'b0; op_i = 3'b000; annul_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0;
        hi_i = '0; lo_i = '0; mem_hi_i = '0; mem_lo_i = '0; wb_hi_i = '0; wb_lo_i = '0;
        mem_whilo_i = 1'b0; wb_whilo_i = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_mult();
        test_back_to_back();
        test_forward();
        test_div_zero();
        test_annul();
        test_reset_mid();
        cmp_cnt++;
        if (sb.size() != 0) begin
            err_cnt++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
